simplebmat_core: RTL and testbench



---
 rtl/simplebmat_pkg.sv | 32 +++
 rtl/bmat_row.sv | 18 +
 rtl/simplebmat_core.sv | 113 +++++++++++
 tb/tb_simplebmat_core.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplebmat_pkg.sv
// Shared constants, mode/state encodings and the operand transpose helper
// for the 8x8 bit-matrix multiply unit.
package simplebmat_pkg;

    localparam int MAT_DIM  = 8;
    localparam int MAT_BITS = MAT_DIM * MAT_DIM;
    localparam int ROW_W    = $clog2(MAT_DIM);

    typedef enum logic {
        BMAT_OR  = 1'b0,
        BMAT_XOR = 1'b1
    } bmat_mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    // Column c of the input becomes byte c of the result, so each result
    // column can be read as a contiguous byte.
    function automatic logic [MAT_BITS-1:0] transpose(input logic [MAT_BITS-1:0] m);
        logic [MAT_BITS-1:0] t;
        t = '0;
        for (int r = 0; r < MAT_DIM; r++) begin
            for (int c = 0; c < MAT_DIM; c++) begin
                t[c*MAT_DIM + r] = m[r*MAT_DIM + c];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/bmat_row.sv
// One result row: each output bit is the rs1 row ANDed with one column of rs2
// (a byte of the transposed rs2), then XOR- or OR-reduced.
module bmat_row
    import simplebmat_pkg::*;
(
    input  logic [MAT_DIM-1:0]  row,
    input  logic [MAT_BITS-1:0] rs2_t,
    input  logic                xoren,
    output logic [MAT_DIM-1:0]  result
);

    for (genvar c = 0; c < MAT_DIM; c++) begin : g_col
        logic [MAT_DIM-1:0] prod;
        assign prod      = row & rs2_t[c*MAT_DIM +: MAT_DIM];
        assign result[c] = xoren ? ^prod : |prod;
    end

endmodule

// File: rtl/simplebmat_core.sv
// Multi-cycle 8x8 bit-matrix multiply (bmatxor/bmator) with a start/busy/done
// handshake; ROWS_PER_CYCLE result rows are produced on every RUN edge.
module simplebmat_core
    import simplebmat_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic                xoren,
    input  logic [MAT_BITS-1:0] rs1,
    input  logic [MAT_BITS-1:0] rs2,
    output logic [MAT_BITS-1:0] rd,
    output logic                busy,
    output logic                done
);

    localparam logic [ROW_W-1:0] ROW_STEP  = ROW_W'(ROWS_PER_CYCLE);
    localparam logic [ROW_W-1:0] LAST_BASE = ROW_W'(MAT_DIM - ROWS_PER_CYCLE);

    state_e              state, state_next;
    logic [ROW_W-1:0]    base_q;
    logic [MAT_BITS-1:0] rs1_q;
    logic [MAT_BITS-1:0] rs2_t_q;
    bmat_mode_e          mode_q;
    logic [MAT_BITS-1:0] rd_q;
    logic                done_q;
    logic                accept;
    logic                last_group;

    logic [ROW_W-1:0]    row_idx [ROWS_PER_CYCLE];
    logic [MAT_DIM-1:0]  row_out [ROWS_PER_CYCLE];

    for (genvar g = 0; g < ROWS_PER_CYCLE; g++) begin : g_row
        assign row_idx[g] = base_q + ROW_W'(g);

        bmat_row u_row (
            .row    (rs1_q[{row_idx[g], 3'b000} +: MAT_DIM]),
            .rs2_t  (rs2_t_q),
            .xoren  (mode_q == BMAT_XOR),
            .result (row_out[g])
        );
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_group = 1'b0;
        busy       = (state == ST_RUN);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (base_q == LAST_BASE) begin
                    last_group = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Finishing the last group raises done for one cycle; an accept (only
    // possible from IDLE) therefore always clears it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            base_q <= '0;
            rd_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_group;
            if (accept) begin
                base_q <= '0;
            end else if (state == ST_RUN) begin
                base_q <= base_q + ROW_STEP;
                for (int g = 0; g < ROWS_PER_CYCLE; g++) begin
                    rd_q[{row_idx[g], 3'b000} +: MAT_DIM] <= row_out[g];
                end
            end
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept
    // before anything reads them.
    always_ff @(posedge clock) begin
        if (accept) begin
            rs1_q   <= rs1;
            rs2_t_q <= transpose(rs2);
            mode_q  <= bmat_mode_e'(xoren);
        end
    end

    assign rd   = rd_q;
    assign done = done_q;

endmodule

// File: tb/tb_simplebmat_core.sv
// Bench for simplebmat_core: four instances (1, 2, 4, 8 rows per cycle) share
// the stimulus and are checked against a plain-arithmetic matrix/timing model.
module tb_simplebmat_core;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        xoren;
    logic [63:0] rs1;
    logic [63:0] rs2;

    logic [63:0] rd_w   [4];
    logic        busy_w [4];
    logic        done_w [4];

    int checks = 0;
    int errors = 0;

    logic [63:0] obs_rd   [4];
    int          obs_lat  [4];
    int          obs_done [4];
    int          obs_busy [4];

    always #5 clock = ~clock;

    for (genvar w = 0; w < 4; w++) begin : g_dut
        simplebmat_core #(.ROWS_PER_CYCLE(1 << w)) u_dut (
            .clock  (clock),
            .resetn (resetn),
            .start  (start),
            .xoren  (xoren),
            .rs1    (rs1),
            .rs2    (rs2),
            .rd     (rd_w[w]),
            .busy   (busy_w[w]),
            .done   (done_w[w])
        );
    end

    function automatic int lat_of(input int w);
        return 8 >> w;
    endfunction

    // rd[8r+c] = reduce over k of rs1[8r+k] & rs2[8k+c]
    function automatic logic [63:0] ref_bmat(input logic [63:0] a, input logic [63:0] b,
                                             input logic x);
        logic [63:0] res;
        logic        acc;
        logic        p;
        res = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                acc = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    p   = a[8*r + k] & b[8*k + c];
                    acc = x ? (acc ^ p) : (acc | p);
                end
                res[8*r + c] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic x);
        start = 1'b1;
        rs1   = a;
        rs2   = b;
        xoren = x;
        tick();
        start = 1'b0;
        rs1   = 'x;
        rs2   = 'x;
        xoren = 1'bx;
    endtask

    // Launch one operation and record, per instance, when done first rose,
    // rd at that moment, how many done pulses and busy cycles were seen.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic x);
        launch(a, b, x);
        for (int w = 0; w < 4; w++) begin
            obs_lat[w]  = 0;
            obs_done[w] = 0;
            obs_busy[w] = busy_w[w] ? 1 : 0;
            obs_rd[w]   = '0;
        end
        for (int t = 1; t <= 12; t++) begin
            tick();
            for (int w = 0; w < 4; w++) begin
                if (busy_w[w]) obs_busy[w]++;
                if (done_w[w]) begin
                    obs_done[w]++;
                    if (obs_lat[w] == 0) begin
                        obs_lat[w] = t;
                        obs_rd[w]  = rd_w[w];
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        xoren  = 1'b0;
        rs1    = '0;
        rs2    = '0;
        tick();
        tick();
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (busy_w[w] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy w%0d: got %b expected 0", w, busy_w[w]);
            end
            checks++;
            if (done_w[w] !== 1'b0) begin
                errors++;
                $display("FAIL reset_done w%0d: got %b expected 0", w, done_w[w]);
            end
            checks++;
            if (rd_w[w] !== 64'h0) begin
                errors++;
                $display("FAIL reset_rd w%0d: got %h expected 0", w, rd_w[w]);
            end
        end
        resetn = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        x;
        logic [63:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t vecs [4];
        vecs[0] = '{64'h8040201008040201, 64'h0123456789abcdef, 1'b1, 64'h0123456789abcdef};
        vecs[1] = '{64'hffffffffffffffff, 64'hffffffffffffffff, 1'b1, 64'h0000000000000000};
        vecs[2] = '{64'hffffffffffffffff, 64'hffffffffffffffff, 1'b0, 64'hffffffffffffffff};
        vecs[3] = '{64'h0102040810204080, 64'h0123456789abcdef, 1'b0, 64'hefcdab8967452301};
        for (int v = 0; v < 4; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].x);
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (obs_rd[w] !== vecs[v].exp) begin
                    errors++;
                    $display("FAIL directed_rd v%0d w%0d: got %h expected %h",
                             v, w, obs_rd[w], vecs[v].exp);
                end
                checks++;
                if (obs_lat[w] != lat_of(w)) begin
                    errors++;
                    $display("FAIL directed_latency v%0d w%0d: got %0d expected %0d",
                             v, w, obs_lat[w], lat_of(w));
                end
                checks++;
                if (obs_done[w] != 1) begin
                    errors++;
                    $display("FAIL directed_done_pulses v%0d w%0d: got %0d expected 1",
                             v, w, obs_done[w]);
                end
                checks++;
                if (obs_busy[w] != lat_of(w)) begin
                    errors++;
                    $display("FAIL directed_busy_cycles v%0d w%0d: got %0d expected %0d",
                             v, w, obs_busy[w], lat_of(w));
                end
            end
        end
    endtask

    // Real starts spaced 9, 11, 13 edges apart plus extra starts during RUN of
    // the slowest instance. The model accepts a start only when the instance
    // is free: free again one edge after its done edge (back-to-back allowed).
    task automatic test_timing();
        int          free_at [4];
        int          done_at [4];
        logic [63:0] pend    [4];
        logic [63:0] last    [4];
        bit          have    [4];
        bit          is_start;
        bit          exp_busy;
        bit          exp_done;
        logic [63:0] a;
        logic [63:0] b;
        logic        x;
        for (int w = 0; w < 4; w++) begin
            free_at[w] = 0;
            done_at[w] = -1;
            pend[w]    = '0;
            last[w]    = '0;
            have[w]    = 1'b0;
        end
        for (int t = 0; t < 50; t++) begin
            is_start = (t == 0) || (t == 9) || (t == 20) || (t == 33) ||
                       (t == 3) || (t == 14) || (t == 25) || (t == 38);
            a = rand64();
            b = rand64();
            x = 1'($urandom_range(0, 1));
            if (is_start) begin
                start = 1'b1;
                rs1   = a;
                rs2   = b;
                xoren = x;
            end else begin
                start = 1'b0;
                rs1   = 'x;
                rs2   = 'x;
                xoren = 1'bx;
            end
            tick();
            for (int w = 0; w < 4; w++) begin
                if (is_start && t >= free_at[w]) begin
                    free_at[w] = t + lat_of(w) + 1;
                    done_at[w] = t + lat_of(w);
                    pend[w]    = ref_bmat(a, b, x);
                end
                exp_busy = (t < free_at[w] - 1);
                exp_done = (t == done_at[w]);
                if (exp_done) begin
                    last[w] = pend[w];
                    have[w] = 1'b1;
                end
                checks++;
                if (busy_w[w] !== exp_busy) begin
                    errors++;
                    $display("FAIL timing_busy t%0d w%0d: got %b expected %b",
                             t, w, busy_w[w], exp_busy);
                end
                checks++;
                if (done_w[w] !== exp_done) begin
                    errors++;
                    $display("FAIL timing_done t%0d w%0d: got %b expected %b",
                             t, w, done_w[w], exp_done);
                end
                if (!exp_busy && have[w]) begin
                    checks++;
                    if (rd_w[w] !== last[w]) begin
                        errors++;
                        $display("FAIL timing_rd t%0d w%0d: got %h expected %h",
                                 t, w, rd_w[w], last[w]);
                    end
                end
            end
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_mid_reset();
        int          pulses [4];
        logic [63:0] a;
        logic [63:0] b;
        launch(rand64(), rand64(), 1'b1);
        tick();
        tick();
        tick();
        resetn = 1'b0;
        tick();
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (busy_w[w] !== 1'b0 || done_w[w] !== 1'b0 || rd_w[w] !== 64'h0) begin
                errors++;
                $display("FAIL midreset_state w%0d: got busy=%b done=%b rd=%h expected busy=0 done=0 rd=0",
                         w, busy_w[w], done_w[w], rd_w[w]);
            end
            pulses[w] = 0;
        end
        resetn = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            for (int w = 0; w < 4; w++) begin
                if (done_w[w]) pulses[w]++;
            end
        end
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (pulses[w] != 0) begin
                errors++;
                $display("FAIL midreset_no_done w%0d: got %0d pulses expected 0", w, pulses[w]);
            end
        end
        a = rand64();
        b = rand64();
        run_op(a, b, 1'b0);
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (obs_rd[w] !== ref_bmat(a, b, 1'b0) || obs_lat[w] != lat_of(w)) begin
                errors++;
                $display("FAIL midreset_restart w%0d: got rd=%h lat=%0d expected rd=%h lat=%0d",
                         w, obs_rd[w], obs_lat[w], ref_bmat(a, b, 1'b0), lat_of(w));
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        for (int n = 0; n < 1000; n++) begin
            a = rand64();
            b = rand64();
            for (int m = 0; m < 2; m++) begin
                exp = ref_bmat(a, b, m[0]);
                run_op(a, b, m[0]);
                for (int w = 0; w < 4; w++) begin
                    checks++;
                    if (obs_rd[w] !== exp) begin
                        errors++;
                        $display("FAIL random_rd n%0d mode%0d w%0d: got %h expected %h",
                                 n, m, w, obs_rd[w], exp);
                    end
                    checks++;
                    if (obs_lat[w] != lat_of(w) || obs_done[w] != 1) begin
                        errors++;
                        $display("FAIL random_done n%0d mode%0d w%0d: got lat=%0d pulses=%0d expected lat=%0d pulses=1",
                                 n, m, w, obs_lat[w], obs_done[w], lat_of(w));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timing();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
